// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: 8N1 UART transmitter fed through a byte FIFO.
//
// Bytes from the upstream formatter are queued in a circular FIFO. A
// serializer pops one byte at a time and shifts it out LSB first as
// start(0), 8 data bits, stop(1). Each bit lasts CLK_DIV clocks. When a
// stop bit ends and another byte is waiting, the next start bit follows
// with no idle gap.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   tx_data     byte to queue
//   tx_valid    write strobe, one byte per high cycle
//   tx_busy     FIFO full; a write in this cycle is rejected
//   ovf_clr     clears the sticky overflow flag (wins over a same-cycle set)
//   uart_txd    registered serial output, idle high
//   fifo_count  bytes queued, excluding the byte being shifted
//   line_idle   FIFO empty and serializer idle
//   overflow    sticky flag, set by a write while full
module uart_tx_buffered #(
    parameter int unsigned CLK_DIV    = 868,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_busy,
    input  logic                          ovf_clr,
    output logic                          uart_txd,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          line_idle,
    output logic                          overflow
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned BW = $clog2(CLK_DIV);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    // FIFO storage and bookkeeping
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          ovf_q,    ovf_d;

    // Serializer state
    logic [1:0]    state_q,  state_d;
    logic [BW-1:0] baud_q,   baud_d;
    logic [2:0]    bit_q,    bit_d;
    logic [7:0]    shift_q,  shift_d;
    logic          txd_q,    txd_d;
    logic          idle_q,   idle_d;

    logic          full_c;
    logic          empty_c;
    logic          push_c;
    logic          pop_c;
    logic          baud_last_c;

    // Full is taken from the registered count only, so a same-cycle pop
    // does not open a slot for a write.
    assign full_c      = (count_q == CW'(FIFO_DEPTH));
    assign empty_c     = (count_q == '0);
    assign push_c      = tx_valid && !full_c;
    assign baud_last_c = (baud_q == BW'(CLK_DIV - 1));

    assign tx_busy    = full_c;
    assign fifo_count = count_q;
    assign uart_txd   = txd_q;
    assign line_idle  = idle_q;
    assign overflow   = ovf_q;

    // FIFO payload write; storage needs no reset since count gates reads
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= tx_data;
        end
    end

    // Serializer next-state: uart_txd is computed for the next state so the
    // pin comes straight from a flop.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        txd_d   = txd_q;
        pop_c   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                txd_d = 1'b1;
                if (!empty_c) begin
                    pop_c   = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    baud_d  = '0;
                    state_d = ST_START;
                    txd_d   = 1'b0;
                end
            end

            ST_START: begin
                if (baud_last_c) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    state_d = ST_DATA;
                    txd_d   = shift_q[0];
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end

            ST_DATA: begin
                if (baud_last_c) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                        txd_d   = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        txd_d   = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end

            ST_STOP: begin
                if (baud_last_c) begin
                    baud_d = '0;
                    // Chain straight into the next start bit when data waits
                    if (!empty_c) begin
                        pop_c   = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        state_d = ST_START;
                        txd_d   = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                        txd_d   = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                baud_d  = '0;
                txd_d   = 1'b1;
            end
        endcase
    end

    // FIFO pointers, count, overflow flag and line_idle next values
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        idle_d   = 1'b0;

        if (push_c) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        case ({push_c, pop_c})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (ovf_clr) begin
            ovf_d = 1'b0;
        end else if (tx_valid && full_c) begin
            ovf_d = 1'b1;
        end

        idle_d = (state_d == ST_IDLE) && (count_d == '0);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            state_q  <= ST_IDLE;
            baud_q   <= '0;
            bit_q    <= 3'd0;
            shift_q  <= 8'h00;
            txd_q    <= 1'b1;
            idle_q   <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            txd_q    <= txd_d;
            idle_q   <= idle_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered with CLK_DIV=4, FIFO_DEPTH=16. A line decoder
// turns uart_txd back into bytes and frame start times; each test compares
// those, and the status outputs, against values derived from the frame rules.
module tb_uart_tx_buffered;

    localparam int CLK_DIV = 4;
    localparam int DEPTH   = 16;
    localparam int FRAME   = 10 * CLK_DIV;

    logic       clk;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_busy;
    logic       ovf_clr;
    logic       uart_txd;
    logic [4:0] fifo_count;
    logic       line_idle;
    logic       overflow;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int fe_cnt = 0;

    logic [7:0] rx_q[$];
    int         start_q[$];
    logic [7:0] exp_q[$];

    uart_tx_buffered #(
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_busy    (tx_busy),
        .ovf_clr    (ovf_clr),
        .uart_txd   (uart_txd),
        .fifo_count (fifo_count),
        .line_idle  (line_idle),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Line decoder: samples mid-bit, records frame start cycle and byte
    initial begin : decoder
        logic [7:0] sh;
        int         ph;
        bit         busy;
        busy = 1'b0;
        ph   = 0;
        sh   = 8'h00;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                busy = 1'b0;
                ph   = 0;
            end else if (!busy) begin
                if (uart_txd === 1'b0) begin
                    busy = 1'b1;
                    ph   = 0;
                    start_q.push_back(cyc);
                end
            end else begin
                ph++;
                if (ph >= CLK_DIV && ph < 9 * CLK_DIV && (ph % CLK_DIV) == CLK_DIV / 2)
                    sh[3'(ph / CLK_DIV - 1)] = uart_txd;
                if (ph == 9 * CLK_DIV + CLK_DIV / 2 && uart_txd !== 1'b1)
                    fe_cnt++;
                if (ph == FRAME - 1) begin
                    busy = 1'b0;
                    rx_q.push_back(sh);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        tx_valid = 1'b0;
        ovf_clr  = 1'b0;
        tx_data  = 8'h00;
        repeat (3) step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (line_idle === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (uart_txd !== 1'b1)   begin errors++; $display("FAIL reset_txd got=%b exp=1", uart_txd); end
        checks++; if (tx_busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got=%b exp=0", tx_busy); end
        checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
        checks++; if (line_idle !== 1'b1)  begin errors++; $display("FAIL reset_idle got=%b exp=1", line_idle); end
        checks++; if (overflow !== 1'b0)   begin errors++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
    endtask

    // Cycle-exact waveform of one frame written into an idle transmitter
    task automatic test_single_byte(input logic [7:0] b);
        logic [9:0] frame;
        logic       exp_txd;
        logic       exp_idle;
        frame = {1'b1, b, 1'b0};
        rx_q.delete();
        start_q.delete();
        tx_data  = b;
        tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
        for (int c = 0; c <= 41; c++) begin
            exp_txd  = (c >= 1 && c <= FRAME) ? frame[(c - 1) / CLK_DIV] : 1'b1;
            exp_idle = (c == FRAME + 1);
            checks++;
            if (uart_txd !== exp_txd) begin
                errors++;
                $display("FAIL single_txd byte=%h cycle=%0d got=%b exp=%b", b, c, uart_txd, exp_txd);
            end
            checks++;
            if (line_idle !== exp_idle) begin
                errors++;
                $display("FAIL single_idle byte=%h cycle=%0d got=%b exp=%b", b, c, line_idle, exp_idle);
            end
            if (c < 41) step();
        end
        checks++;
        if (rx_q.size() != 1 || rx_q[0] !== b) begin
            errors++;
            $display("FAIL single_decode got_n=%0d got=%h exp=%h", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx, b);
        end
    endtask

    // Consecutive writes must come out as contiguous frames in order
    task automatic test_burst(input logic [7:0] bytes[$]);
        bit ok;
        int n;
        int t_idle;
        n = bytes.size();
        rx_q.delete();
        start_q.delete();
        fe_cnt = 0;
        foreach (bytes[i]) begin
            tx_data  = bytes[i];
            tx_valid = 1'b1;
            step();
        end
        tx_valid = 1'b0;
        wait_idle(n * FRAME + 20, ok);
        t_idle = cyc;
        checks++; if (!ok) begin errors++; $display("FAIL burst_timeout got=busy exp=idle n=%0d", n); end
        checks++;
        if (rx_q.size() != n) begin
            errors++;
            $display("FAIL burst_count got=%0d exp=%0d", rx_q.size(), n);
        end
        for (int i = 0; i < n && i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[i] !== bytes[i]) begin
                errors++;
                $display("FAIL burst_byte idx=%0d got=%h exp=%h", i, rx_q[i], bytes[i]);
            end
        end
        for (int i = 1; i < start_q.size(); i++) begin
            checks++;
            if (start_q[i] - start_q[i-1] != FRAME) begin
                errors++;
                $display("FAIL burst_gap idx=%0d got=%0d exp=%0d", i, start_q[i] - start_q[i-1], FRAME);
            end
        end
        checks++;
        if (start_q.size() == 0 || t_idle - start_q[0] != n * FRAME) begin
            errors++;
            $display("FAIL burst_span got=%0d exp=%0d", (start_q.size() > 0) ? t_idle - start_q[0] : -1, n * FRAME);
        end
        checks++; if (fe_cnt != 0) begin errors++; $display("FAIL burst_stopbit got=%0d exp=0", fe_cnt); end
    endtask

    // DEPTH+1 back-to-back writes accepted, then rejection and sticky flag
    task automatic test_fill_overflow();
        logic [7:0] b;
        rx_q.delete();
        start_q.delete();
        exp_q.delete();
        fe_cnt = 0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            b = 8'($urandom);
            checks++;
            if (tx_busy !== 1'b0) begin
                errors++;
                $display("FAIL fill_busy_early idx=%0d got=%b exp=0", i, tx_busy);
            end
            tx_data  = b;
            tx_valid = 1'b1;
            step();
            exp_q.push_back(b);
        end
        checks++; if (tx_busy !== 1'b1)      begin errors++; $display("FAIL fill_busy got=%b exp=1", tx_busy); end
        checks++; if (fifo_count !== 5'(DEPTH)) begin errors++; $display("FAIL fill_count got=%0d exp=%0d", fifo_count, DEPTH); end
        checks++; if (overflow !== 1'b0)     begin errors++; $display("FAIL fill_ovf_early got=%b exp=0", overflow); end
        tx_data = 8'($urandom);
        step();
        tx_valid = 1'b0;
        checks++; if (overflow !== 1'b1)     begin errors++; $display("FAIL ovf_set got=%b exp=1", overflow); end
        checks++; if (fifo_count !== 5'(DEPTH)) begin errors++; $display("FAIL ovf_count got=%0d exp=%0d", fifo_count, DEPTH); end
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        checks++; if (overflow !== 1'b0)     begin errors++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
        tx_data  = 8'($urandom);
        tx_valid = 1'b1;
        ovf_clr  = 1'b1;
        step();
        tx_valid = 1'b0;
        ovf_clr  = 1'b0;
        checks++; if (overflow !== 1'b0)     begin errors++; $display("FAIL ovf_clr_priority got=%b exp=0", overflow); end
        checks++; if (fifo_count !== 5'(DEPTH)) begin errors++; $display("FAIL ovf_clr_count got=%0d exp=%0d", fifo_count, DEPTH); end
    endtask

    // Write on the last stop cycle while full: rejected although a pop happens
    task automatic test_simul_push_pop();
        bit         ok;
        int         s;
        logic [7:0] b;
        checks++;
        if (start_q.size() == 0) begin
            errors++;
            $display("FAIL pushpop_nostart got=0 exp=1 frames started");
            return;
        end
        s = start_q[0];
        while (cyc < s + FRAME - 1) step();
        checks++; if (tx_busy !== 1'b1) begin errors++; $display("FAIL pushpop_pre_busy got=%b exp=1", tx_busy); end
        tx_data  = 8'($urandom);
        tx_valid = 1'b1;
        step();
        checks++; if (fifo_count !== 5'(DEPTH - 1)) begin errors++; $display("FAIL pushpop_count got=%0d exp=%0d", fifo_count, DEPTH - 1); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL pushpop_ovf got=%b exp=1", overflow); end
        b = 8'($urandom);
        tx_data = b;
        step();
        tx_valid = 1'b0;
        exp_q.push_back(b);
        checks++; if (fifo_count !== 5'(DEPTH)) begin errors++; $display("FAIL pushpop_refill got=%0d exp=%0d", fifo_count, DEPTH); end
        checks++; if (tx_busy !== 1'b1) begin errors++; $display("FAIL pushpop_busy got=%b exp=1", tx_busy); end
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        wait_idle((DEPTH + 3) * FRAME, ok);
        checks++; if (!ok) begin errors++; $display("FAIL pushpop_timeout got=busy exp=idle"); end
        checks++;
        if (rx_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL pushpop_nbytes got=%0d exp=%0d", rx_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL pushpop_byte idx=%0d got=%h exp=%h", i, rx_q[i], exp_q[i]);
            end
        end
        for (int i = 1; i < start_q.size(); i++) begin
            checks++;
            if (start_q[i] - start_q[i-1] != FRAME) begin
                errors++;
                $display("FAIL pushpop_gap idx=%0d got=%0d exp=%0d", i, start_q[i] - start_q[i-1], FRAME);
            end
        end
        checks++; if (fe_cnt != 0) begin errors++; $display("FAIL pushpop_stopbit got=%0d exp=0", fe_cnt); end
    endtask

    // Asynchronous reset during data bit 3 of the first frame
    task automatic test_reset_mid_frame();
        int s;
        int high_bad;
        rx_q.delete();
        start_q.delete();
        for (int i = 0; i < 3; i++) begin
            tx_data  = 8'($urandom) & 8'hF7;
            tx_valid = 1'b1;
            step();
        end
        tx_valid = 1'b0;
        checks++;
        if (start_q.size() == 0) begin
            errors++;
            $display("FAIL rstmid_nostart got=0 exp=1 frames started");
            return;
        end
        s = start_q[0];
        while (cyc < s + CLK_DIV + 3 * CLK_DIV + 1) step();
        checks++; if (uart_txd !== 1'b0) begin errors++; $display("FAIL rstmid_bit3 got=%b exp=0", uart_txd); end
        checks++; if (fifo_count !== 5'd2) begin errors++; $display("FAIL rstmid_precount got=%0d exp=2", fifo_count); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (uart_txd !== 1'b1)   begin errors++; $display("FAIL rstmid_txd got=%b exp=1", uart_txd); end
        checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL rstmid_count got=%0d exp=0", fifo_count); end
        checks++; if (line_idle !== 1'b1)  begin errors++; $display("FAIL rstmid_idle got=%b exp=1", line_idle); end
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        high_bad = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (uart_txd !== 1'b1) high_bad++;
        end
        checks++; if (high_bad != 0)       begin errors++; $display("FAIL rstmid_line_low got=%0d exp=0 low cycles", high_bad); end
        checks++; if (rx_q.size() != 0)    begin errors++; $display("FAIL rstmid_rx got=%0d exp=0 bytes", rx_q.size()); end
        checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL rstmid_after_count got=%0d exp=0", fifo_count); end
    endtask

    // Random producer that respects tx_busy: no overflow, order preserved
    task automatic test_handshake();
        bit         ok;
        bit         saw_busy;
        int         sent;
        int         budget;
        logic [7:0] b;
        rx_q.delete();
        start_q.delete();
        exp_q.delete();
        fe_cnt   = 0;
        sent     = 0;
        budget   = 0;
        saw_busy = 1'b0;
        while (sent < 40 && budget < 20000) begin
            if (tx_busy === 1'b1) saw_busy = 1'b1;
            if (tx_busy === 1'b0 && $urandom_range(0, 3) != 0) begin
                b        = 8'($urandom);
                tx_data  = b;
                tx_valid = 1'b1;
                exp_q.push_back(b);
                sent++;
            end else begin
                tx_valid = 1'b0;
            end
            step();
            budget++;
        end
        tx_valid = 1'b0;
        wait_idle(42 * FRAME, ok);
        checks++; if (!ok)              begin errors++; $display("FAIL hs_timeout got=busy exp=idle"); end
        checks++; if (sent != 40)       begin errors++; $display("FAIL hs_sent got=%0d exp=40", sent); end
        checks++; if (!saw_busy)        begin errors++; $display("FAIL hs_backpressure got=0 exp=1"); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL hs_ovf got=%b exp=0", overflow); end
        checks++;
        if (rx_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL hs_nbytes got=%0d exp=%0d", rx_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL hs_byte idx=%0d got=%h exp=%h", i, rx_q[i], exp_q[i]);
            end
        end
        checks++; if (fe_cnt != 0) begin errors++; $display("FAIL hs_stopbit got=%0d exp=0", fe_cnt); end
    endtask

    initial begin
        logic [7:0] mx[$];
        logic [7:0] rb[$];
        int         n;
        rst_n    = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        ovf_clr  = 1'b0;

        test_reset();
        test_single_byte(8'h55);
        test_single_byte(8'($urandom));

        mx = '{8'h4D, 8'h61, 8'h74, 8'h72, 8'h69, 8'h78};
        test_burst(mx);
        n = $urandom_range(2, 10);
        for (int i = 0; i < n; i++) rb.push_back(8'($urandom));
        test_burst(rb);

        test_fill_overflow();
        test_simul_push_pop();
        test_reset_mid_frame();
        test_handshake();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_buffered.md
# uart_tx_buffered

Byte-stream UART transmitter with an input FIFO. It sits directly downstream of the matrix display formatter and accepts its `tx_data`/`tx_valid` byte stream, using `tx_busy` as back-pressure. It serializes bytes onto the board TX pin as 8N1 frames. The FIFO absorbs header and matrix bursts so the formatter rarely stalls.

## Interface

- `CLK_DIV`, 868: clock cycles per bit (100 MHz / 115200); legal range ≥ 2.
- `FIFO_DEPTH`, 16: byte entries; power of two, ≥ 2.

- `clk` input 1: system clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `tx_data` input 8: byte to transmit.
- `tx_valid` input 1: write strobe, one byte per high cycle.
- `tx_busy` output 1: FIFO full; a write in this cycle is rejected.
- `ovf_clr` input 1: clears `overflow`.
- `uart_txd` output 1: serial line, idle high.
- `fifo_count` output $clog2(FIFO_DEPTH)+1: bytes currently queued, excluding the byte being shifted.
- `line_idle` output 1: FIFO empty and serializer in IDLE.
- `overflow` output 1: sticky flag, set when a write arrives while full.

## Operation

- **FIFO**
  - Circular buffer with wrap-around read and write pointers plus an explicit count.
  - `tx_busy` = (`fifo_count` == FIFO_DEPTH). It is combinational from the registered count and ignores a pop in the same cycle.
  - Write happens when `tx_valid && !tx_busy`.
  - `tx_valid` while full: byte dropped, `overflow` ← 1.
  - `ovf_clr` has priority over a same-cycle set.
  - Simultaneous write and pop: count unchanged, both pointers advance.
- **Serializer FSM**: IDLE, START, DATA, STOP.
  - IDLE: if `fifo_count` ≠ 0, pop head into an 8-bit shift register and go to START; otherwise `uart_txd` = 1.
  - START: `uart_txd` = 0 for CLK_DIV cycles, then go to DATA.
  - DATA: drive shift[0] for CLK_DIV cycles, shift right, repeat for 8 bits (LSB first, 3-bit bit counter), then go to STOP.
  - STOP: `uart_txd` = 1 for CLK_DIV cycles. On the last STOP cycle, if the FIFO is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- **Counters and output**
  - Baud counter is $clog2(CLK_DIV) bits, reloaded to 0 on every state or bit change. No fractional baud.
  - `uart_txd` is a registered output (glitch-free).
- **Reset values**: `uart_txd`=1, `tx_busy`=0, `fifo_count`=0, `line_idle`=1, `overflow`=0.
- **Reset mid-frame**: line returns high immediately (asynchronous) and all queued bytes are discarded.

## Timing

- **Write-to-start-bit latency**
  - Byte written at edge E0 into an empty FIFO with the serializer in IDLE.
  - Pop occurs at edge E1; `uart_txd` falls after E1.
  - Latency is 1 cycle.
- **Frame length**
  - Each frame is exactly 10×CLK_DIV cycles.
  - N queued bytes take N×10×CLK_DIV cycles contiguously.
- **Back-pressure capacity**
  - `tx_busy` is asserted the cycle after the write that fills the FIFO.
  - Because the serializer holds one byte outside the FIFO, FIFO_DEPTH+1 back-to-back writes are accepted before the first rejection.
- **Status flags**
  - `line_idle` rises the cycle after the final STOP bit completes.
  - `overflow` rises the cycle after the offending write.

## Test plan

- **Single byte**: CLK_DIV=4; write 0x55 at cycle 0 → `uart_txd` low for cycles 1–4, then bits 1,0,1,0,1,0,1,0 for 4 cycles each, high for cycles 37–40; `line_idle`=1 at cycle 41.
- **Burst**: write "Matrix" (6 bytes) on consecutive cycles → 6 contiguous frames, 240 cycles with no idle gaps, decoded bytes 0x4D 0x61 0x74 0x72 0x69 0x78.
- **Fill and overflow**: FIFO_DEPTH=16; write 17 bytes on consecutive cycles → all accepted, `tx_busy`=1, `fifo_count`=16. An 18th write is dropped and sets `overflow`. `ovf_clr` pulse clears `overflow`, and the line output omits the 18th byte.
- **Simultaneous push/pop**: with the FIFO full, write on the cycle STOP ends → write rejected, `fifo_count` 16→15. Write next cycle → accepted, count 16.
- **Reset mid-frame**: assert `rst_n`=0 during DATA bit 3 → `uart_txd`=1 within the same cycle and `fifo_count`=0. After release with no writes, the line stays high.
- **Formatter handshake**: drive a model that sends only when `!tx_busy` → no `overflow`, and the byte order is preserved.
